// File: rtl/mcdp_pkg.sv
// Shared constants for the multi-cycle datapath: opcodes, R-type functs,
// instruction field positions and the control FSM state encoding.
package mcdp_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;

  localparam int OPC_LSB = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int FN_LSB  = 0;
  localparam int IMM_W   = 12;
  localparam int JT_W    = 20;
  localparam int INSN_W  = 24;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/mcdp_if.sv
// Shared memory port of the multi-cycle datapath (fetch and load/store).
interface mcdp_if #(
  parameter int DATA_W = 24
);
  // req/ack: the master raises mem_req and holds mem_addr/mem_we/mem_wdata
  // stable until the slave pulses mem_ack for one cycle (read data valid in
  // that cycle); an ack while mem_req is low carries no meaning.
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mcdp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// entry 0 always reads as zero and ignores writes.
module mcdp_regfile #(
  parameter int REG_AW = 4,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs [2**REG_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle 24-bit-ISA datapath with inline control FSM and ALU, sharing
// one req/ack memory port between instruction fetch and load/store.
module multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int REG_AW   = 4,
  parameter int PC_RESET = 10,
  parameter int PC_STEP  = 3,
  parameter int CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  mcdp_if.master            mem,
  output logic              halted,
  output logic [DATA_W-1:0] pc,
  output logic [CNT_W-1:0]  retired,
  output logic              ovf,
  output state_t            state
);
  state_t            state_nxt;
  logic              started;
  logic [INSN_W-1:0] ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  logic [DATA_W-1:0] rd1, rd2, imm_sx, jtarget, opb, sum, diff, alu_res;
  logic [DATA_W-1:0] pc_seq, pc_br, pc_val, rf_wd;
  logic [3:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd, rf_wa;
  logic              add_ovf, sub_ovf, alu_ovf;
  logic              req, retire, pc_load, rf_we;

  assign opcode  = ir[OPC_LSB +: 4];
  assign funct   = ir[FN_LSB +: 4];
  assign rs      = REG_AW'(ir[RS_LSB +: 4]);
  assign rt      = REG_AW'(ir[RT_LSB +: 4]);
  assign rd      = REG_AW'(ir[RD_LSB +: 4]);
  assign imm_sx  = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign jtarget = {{(DATA_W-JT_W){1'b0}}, ir[JT_W-1:0]};
  assign pc_seq  = pc + DATA_W'(PC_STEP);
  assign pc_br   = pc_seq + imm_sx * DATA_W'(PC_STEP);

  mcdp_regfile #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_regfile (
    .clk(Clock), .rst_n(Resetn),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
  );

  always_comb begin
    opb     = (opcode == OP_R) ? b : imm_sx;
    sum     = a + opb;
    diff    = a - opb;
    add_ovf = (a[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    sub_ovf = (a[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    alu_res = sum;
    alu_ovf = 1'b0;
    if (opcode == OP_R) begin
      case (funct)
        FN_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
        FN_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
        FN_AND:  alu_res = a & opb;
        FN_OR:   alu_res = a | opb;
        FN_XOR:  alu_res = a ^ opb;
        FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(opb))};
        default: alu_res = '0;
      endcase
    end else if (opcode == OP_ADDI) begin
      alu_ovf = add_ovf;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    retire    = 1'b0;
    pc_load   = 1'b0;
    pc_val    = pc_seq;
    rf_we     = 1'b0;
    rf_wa     = (opcode == OP_R) ? rd : rt;
    rf_wd     = (opcode == OP_LW) ? mdr : alu_out;
    case (state)
      S_FETCH: begin
        // started keeps the port quiet until the first edge after reset
        req = started;
        if (started && mem.mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_R, OP_ADDI: state_nxt = S_WB;
          OP_LW, OP_SW:  state_nxt = S_MEM;
          OP_HALT: begin
            retire    = 1'b1;
            state_nxt = S_HALT;
          end
          default: begin
            pc_load   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
            if (opcode == OP_BEQ && a == b) pc_val = pc_br;
            if (opcode == OP_BNE && a != b) pc_val = pc_br;
            if (opcode == OP_J)             pc_val = jtarget;
          end
        endcase
      end
      S_MEM: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          if (opcode == OP_SW) begin
            pc_load   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_load   = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= DATA_W'(PC_RESET);
      retired <= '0;
      ovf     <= 1'b0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (state == S_FETCH && req && mem.mem_ack) ir <= mem.mem_rdata[INSN_W-1:0];
      if (state == S_DECODE) begin
        a <= rd1;
        b <= rd2;
      end
      if (state == S_EXEC) begin
        alu_out <= alu_res;
        ovf     <= ovf | alu_ovf;
      end
      if (state == S_MEM && mem.mem_ack && opcode == OP_LW) mdr <= mem.mem_rdata;
      if (pc_load) pc <= pc_val;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = req && (state == S_MEM) && (opcode == OP_SW);
  assign mem.mem_addr  = !req ? '0 : ((state == S_FETCH) ? pc : alu_out);
  assign mem.mem_wdata = mem.mem_we ? b : '0;
  assign halted        = (state == S_HALT);
endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: small programs run against a wait-state
// memory model; stores are scored against an expected queue.
module tb_multicycle_datapath;
  import mcdp_pkg::*;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              halted, ovf;
  logic [DATA_W-1:0] pc;
  logic [CNT_W-1:0]  retired;
  state_t            dbg_state;

  mcdp_if #(.DATA_W(DATA_W)) bus ();

  multicycle_datapath #(
    .DATA_W(DATA_W), .REG_AW(4), .PC_RESET(10), .PC_STEP(3), .CNT_W(CNT_W)
  ) dut (
    .Clock(clk), .Resetn(rst_n), .mem(bus),
    .halted(halted), .pc(pc), .retired(retired), .ovf(ovf), .state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mem [256];
  logic [47:0]       exp_q [$];

  logic              stray_ack, rand_wait, busy, req_we;
  logic [DATA_W-1:0] watch_addr, req_addr, req_wdata;
  int                watch_wait, watch_hold, wcnt, wtarget, hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] enc_i(input logic [3:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [11:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [23:0] enc_r(input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [3:0] rd, input logic [3:0] fn);
    return {OP_R, rs, rt, rd, 4'h0, fn};
  endfunction

  function automatic logic [23:0] enc_j(input logic [19:0] target);
    return {OP_J, target};
  endfunction

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_pc", pc, 10);
    check("rst_retired", retired, 0);
    check("rst_ovf", ovf, 0);
    check("rst_halted", halted, 0);
    check("rst_state", dbg_state, S_FETCH);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int budget, output int waited);
    waited = 0;
    while (!bus.mem_req && waited < budget) begin
      step();
      waited++;
    end
  endtask

  task automatic wait_retired(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(retired) != target && n < budget) begin
      step();
      n++;
    end
    check(tag, retired, target);
  endtask

  // memory model and store scoreboard
  initial begin : responder
    logic [47:0] exp_item;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    busy          = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (bus.mem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          wcnt      = 0;
          hold      = 0;
          req_addr  = bus.mem_addr;
          req_we    = bus.mem_we;
          req_wdata = bus.mem_wdata;
          if (bus.mem_addr == watch_addr) wtarget = watch_wait;
          else if (rand_wait)             wtarget = $urandom_range(0, 2);
          else                            wtarget = 0;
        end else begin
          check("addr_stable", bus.mem_addr, req_addr);
          check("we_stable", bus.mem_we, req_we);
          check("wdata_stable", bus.mem_wdata, req_wdata);
        end
        hold++;
        if (wcnt == wtarget) begin
          bus.mem_ack = 1'b1;
          busy        = 1'b0;
          if (req_addr == watch_addr) watch_hold = hold;
          if (req_we) begin
            exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("sb_wr_addr", req_addr, exp_item[47:24]);
            check("sb_wr_data", req_wdata, exp_item[23:0]);
            if (req_addr < 256) mem[req_addr[7:0]] = req_wdata;
          end else if (req_addr < 256) begin
            bus.mem_rdata = mem[req_addr[7:0]];
          end
        end else begin
          wcnt++;
        end
      end else begin
        busy = 1'b0;
        if (stray_ack) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = {OP_HALT, 20'h0};
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst_n      = 1'b1;
    stray_ack  = 1'b0;
    rand_wait  = 1'b0;
    watch_addr = '1;
    watch_wait = 0;
    watch_hold = 0;

    // ADDI latency, SW, BEQ taken backwards (zero-wait memory)
    clear_mem();
    mem[10] = enc_i(OP_ADDI, 4'd0, 4'd1, 12'd5);
    mem[13] = enc_i(OP_SW, 4'd0, 4'd1, 12'd100);
    mem[16] = enc_i(OP_BEQ, 4'd1, 4'd1, 12'hFFE);
    exp_q.push_back({24'd100, 24'd5});
    @(negedge clk);
    do_reset();
    wait_req(10, n);
    check("a_first_addr", bus.mem_addr, 10);
    n = 0;
    while (retired != 1 && n < 20) begin
      step();
      n++;
    end
    check("a_addi_latency", n, 4);
    check("a_addi_pc", pc, 13);
    wait_retired("a_ret2", 2, 40);
    check("a_sw_pc", pc, 16);
    wait_retired("a_ret3", 3, 40);
    check("a_beq_pc", pc, 13);
    check("a_sb_drained", exp_q.size(), 0);

    // LW with three wait states, SW of the loaded value, HALT
    clear_mem();
    mem[9]  = 24'h00ABCD;
    mem[10] = enc_i(OP_ADDI, 4'd0, 4'd1, 12'd5);
    mem[13] = enc_i(OP_LW, 4'd1, 4'd2, 12'd4);
    mem[16] = enc_i(OP_SW, 4'd0, 4'd2, 12'd100);
    mem[19] = {OP_HALT, 20'h0};
    exp_q.push_back({24'd100, 24'h00ABCD});
    watch_addr = 9;
    watch_wait = 3;
    watch_hold = 0;
    do_reset();
    wait_retired("b_ret2", 2, 60);
    check("b_lw_pc", pc, 16);
    check("b_lw_hold", watch_hold, 4);
    wait_retired("b_ret4", 4, 60);
    check("b_halted", halted, 1);
    check("b_halt_pc", pc, 19);
    stray_ack = 1'b1;
    n = 0;
    repeat (20) begin
      step();
      if (bus.mem_req) n++;
    end
    stray_ack = 1'b0;
    check("b_halt_no_req", n, 0);
    check("b_halt_pc_frozen", pc, 19);
    check("b_halt_ret_frozen", retired, 4);
    check("b_halt_stays", halted, 1);
    check("b_sb_drained", exp_q.size(), 0);
    watch_addr = '1;

    // J forward, BEQ taken backwards into the J again
    clear_mem();
    mem[10] = enc_i(OP_ADDI, 4'd0, 4'd1, 12'd5);
    mem[13] = enc_j(20'h00010);
    mem[16] = enc_i(OP_BEQ, 4'd1, 4'd1, 12'hFFE);
    do_reset();
    wait_retired("c_ret2", 2, 40);
    check("c_j_pc", pc, 16);
    wait_retired("c_ret3", 3, 40);
    check("c_beq_pc", pc, 13);
    wait_retired("c_ret4", 4, 40);
    check("c_j_again_pc", pc, 16);

    // J far, BNE not taken / taken, NOP opcode, HALT (random wait states)
    rand_wait = 1'b1;
    clear_mem();
    mem[10]   = enc_i(OP_ADDI, 4'd0, 4'd1, 12'd5);
    mem[13]   = enc_j(20'h00040);
    mem[8'h40] = enc_i(OP_BNE, 4'd1, 4'd1, 12'hFFE);
    mem[8'h43] = enc_i(OP_BNE, 4'd1, 4'd0, 12'd1);
    mem[8'h49] = enc_i(4'd7, 4'd0, 4'd0, 12'd0);
    mem[8'h4C] = {OP_HALT, 20'h0};
    do_reset();
    wait_retired("d_ret2", 2, 80);
    check("d_j_pc", pc, 24'h40);
    check("d_j_fetch_addr", bus.mem_addr, 24'h40);
    wait_retired("d_ret3", 3, 80);
    check("d_bne_nt_pc", pc, 24'h43);
    wait_retired("d_ret4", 4, 80);
    check("d_bne_t_pc", pc, 24'h49);
    wait_retired("d_ret5", 5, 80);
    check("d_nop_pc", pc, 24'h4C);
    wait_retired("d_ret6", 6, 80);
    check("d_halted", halted, 1);
    check("d_halt_pc", pc, 24'h4C);

    // ALU functions, signed overflow stickiness, R0 write discard
    clear_mem();
    mem[200] = 24'h7FFFFF;
    mem[10] = enc_i(OP_LW, 4'd0, 4'd1, 12'd200);
    mem[13] = enc_i(OP_ADDI, 4'd0, 4'd2, 12'd1);
    mem[16] = enc_r(4'd1, 4'd2, 4'd3, FN_ADD);
    mem[19] = enc_i(OP_SW, 4'd0, 4'd3, 12'd100);
    mem[22] = enc_r(4'd2, 4'd2, 4'd4, FN_ADD);
    mem[25] = enc_i(OP_SW, 4'd0, 4'd4, 12'd101);
    mem[28] = enc_r(4'd3, 4'd2, 4'd5, FN_SLT);
    mem[31] = enc_i(OP_SW, 4'd0, 4'd5, 12'd102);
    mem[34] = enc_r(4'd2, 4'd1, 4'd6, FN_SUB);
    mem[37] = enc_i(OP_SW, 4'd0, 4'd6, 12'd103);
    mem[40] = enc_r(4'd1, 4'd3, 4'd7, FN_XOR);
    mem[43] = enc_i(OP_SW, 4'd0, 4'd7, 12'd104);
    mem[46] = enc_r(4'd2, 4'd4, 4'd8, FN_OR);
    mem[49] = enc_i(OP_SW, 4'd0, 4'd8, 12'd105);
    mem[52] = enc_i(OP_ADDI, 4'd0, 4'd0, 12'd7);
    mem[55] = enc_i(OP_SW, 4'd0, 4'd0, 12'd106);
    mem[58] = {OP_HALT, 20'h0};
    exp_q.push_back({24'd100, 24'h800000});
    exp_q.push_back({24'd101, 24'h000002});
    exp_q.push_back({24'd102, 24'h000001});
    exp_q.push_back({24'd103, 24'h800002});
    exp_q.push_back({24'd104, 24'hFFFFFF});
    exp_q.push_back({24'd105, 24'h000003});
    exp_q.push_back({24'd106, 24'h000000});
    do_reset();
    wait_retired("e_ret2", 2, 80);
    check("e_ovf_clear", ovf, 0);
    wait_retired("e_ret3", 3, 40);
    check("e_ovf_set", ovf, 1);
    wait_retired("e_ret17", 17, 400);
    check("e_halted", halted, 1);
    check("e_halt_pc", pc, 58);
    check("e_ovf_sticky", ovf, 1);
    check("e_sb_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a stalled LW, stray acks around release
    rand_wait = 1'b0;
    clear_mem();
    mem[9]  = 24'h00ABCD;
    mem[10] = enc_i(OP_ADDI, 4'd0, 4'd1, 12'd5);
    mem[13] = enc_i(OP_LW, 4'd1, 4'd2, 12'd4);
    mem[16] = {OP_HALT, 20'h0};
    watch_addr = 9;
    watch_wait = 50;
    do_reset();
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 9) && n < 40) begin
      step();
      n++;
    end
    check("f_lw_issued", bus.mem_addr, 9);
    step();
    step();
    check("f_lw_pending", bus.mem_req, 1);
    stray_ack = 1'b1;
    do_reset();
    repeat (3) step();
    stray_ack = 1'b0;
    wait_retired("f_ret1", 1, 40);
    check("f_restart_pc", pc, 13);
    check("f_not_halted", halted, 0);
    check("f_sb_drained", exp_q.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle 24-bit datapath.
- Contains its own control FSM, register file, ALU and PC logic, so no external CU is needed.
- One shared memory port serves both fetch and load/store, using a req/ack handshake with arbitrary wait states.
- Adds BNE, JUMP, HALT and a retired-instruction counter; the single-cycle version has none of these.

Parameters:
- DATA_W, 24, datapath, instruction and address width (min 24).
- REG_AW, 4, register index width; register file has 2**REG_AW entries, R0 hard-wired to 0.
- PC_RESET, 10, PC value after reset.
- PC_STEP, 3, PC increment per instruction; branch offsets are scaled by this.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- mem_req  out  1  memory request; held high until accepted
- mem_we  out  1  1 = write (SW), 0 = read (fetch or LW)
- mem_addr  out  DATA_W  request address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge
- halted  out  1  high after HALT retires
- pc  out  DATA_W  current PC
- retired  out  CNT_W  retired-instruction count, wraps
- ovf  out  1  sticky signed overflow from ADD/SUB/ADDI

Behaviour:
- Instruction fields:
  - opcode = [23:20], rs = [19:16], rt = [15:12], rd = [11:8], funct = [3:0].
  - imm = [11:0], sign-extended to DATA_W.
  - jtarget = [19:0], zero-extended.
  - Bits above 23 are ignored when DATA_W > 24.
- Opcodes:
  - 0 = R-type, 1 = ADDI, 2 = LW, 3 = SW, 4 = BEQ, 5 = BNE, 6 = J, 15 = HALT.
  - Any other opcode retires as a NOP.
- R-type funct:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0 or 1).
  - Any other funct writes 0.
- Arithmetic: modulo 2**DATA_W. ovf is set on signed overflow and cleared only by reset.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack, latch IR and go to DECODE.
- DECODE (1 cycle): read rs and rt into operand registers A and B.
- EXEC (1 cycle):
  - ALU computes A op (B or imm).
  - LW and SW compute A + imm and go to MEM.
  - R-type and ADDI go to WB.
  - BEQ/BNE compare A and B. If taken, pc = pc + PC_STEP + imm*PC_STEP; else pc = pc + PC_STEP. Retire, then FETCH.
  - J sets pc = jtarget, retires, then FETCH.
  - HALT retires and goes to HALT.
  - NOP sets pc = pc + PC_STEP, retires, then FETCH.
- MEM:
  - Drive mem_req=1 with the computed address. SW sets mem_we=1 and mem_wdata=B.
  - Stay in MEM until mem_ack.
  - SW then does pc += PC_STEP, retires, and goes to FETCH. LW goes to WB.
- WB (1 cycle):
  - Destination is rd for R-type, rt for ADDI/LW.
  - Writes to R0 are discarded.
  - Then pc += PC_STEP, retire, FETCH.
- Retire means retired increments by 1 in that same cycle.
- HALT state: no requests are issued. halted=1, pc and retired are frozen, and only reset exits.
- Latencies, excluding wait states:
  - R/ADDI = 4 cycles
  - LW = 5 cycles
  - SW = 4 cycles
  - branch/J/NOP = 3 cycles
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
  - mem_ack seen while mem_req=0 is ignored.
  - mem_req drops in the cycle after ack.
- Reset (asynchronous, including mid-transaction):
  - pc=PC_RESET, state=FETCH, retired=0, ovf=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All registers are cleared to 0.
  - The first request is issued in the first clock after Resetn rises.
- Register file: asynchronous read, synchronous write. Read-during-write returns the old value; this is safe because DECODE and WB never coincide.

Decomposition:
- Package mcdp_pkg holds:
  - opcode constants (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT)
  - funct constants
  - state enum
  - field bit-position constants
- One sub-module, mcdp_regfile: parametrised REG_AW/DATA_W, two read ports, one write port, R0 forced to 0.
- ALU and FSM stay inline.

Test Plan:
- Reset with zero-wait memory: ADDI R1,R0,5 at addr 10 → first mem_addr=10; R1=5 after 4 cycles; pc=13; retired=1.
- LW R2,4(R1) with memory returning 0x00ABCD after 3 wait cycles → mem_addr=9 held 4 cycles; R2=0x00ABCD; pc advances by 3.
- BEQ R1,R1,imm=-2 at pc=16 → pc=13. Same with BNE → pc=19. retired increments by 1 each.
- J with jtarget=0x00040 → next fetch address=0x40.
- ADD 0x7FFFFF+1 → result 0x800000; ovf=1 and stays high after a later non-overflowing ADD.
- HALT → halted=1, mem_req stays 0 for 20 cycles. Resetn pulsed low mid-LW (mem_req high) → mem_req drops immediately; pc=10; retired=0.
